// File: rtl/gf180mcu_fd_io__seg_seq_pkg.sv
// Shared types and sizing helpers for the pad-ring segment sequencer.
package gf180mcu_fd_io__seg_seq_pkg;

  localparam int NSEG_MAX   = 32;
  localparam int SETTLE_MIN = 1;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    UP   = 2'd1,
    ON   = 2'd2,
    DOWN = 2'd3
  } state_t;

  function automatic int cnt_width(input int settle);
    int s;
    s = (settle < SETTLE_MIN) ? SETTLE_MIN : settle;
    return $clog2(s + 1);
  endfunction

  function automatic int lvl_width(input int nseg);
    int n;
    n = (nseg < 1) ? 1 : ((nseg > NSEG_MAX) ? NSEG_MAX : nseg);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_io__seg_seq_tmr.sv
// Reloadable settle down-counter; zero flags the end of a settle interval.
module gf180mcu_fd_io__seg_seq_tmr #(
  parameter int SETTLE_CYC = 16,
  parameter int CW         = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (en && !zero) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gf180mcu_fd_io__seg_seq.sv
// Pad-ring power sequencer: thermometer segment enables, staged up/down.
// Optional power-good abort enabled by GF180MCU_FD_IO_SEG_SEQ_PWRGOOD_EN.
module gf180mcu_fd_io__seg_seq
  import gf180mcu_fd_io__seg_seq_pkg::*;
#(
  parameter int NSEG       = 4,
  parameter int SETTLE_CYC = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            STOP,
`ifdef GF180MCU_FD_IO_SEG_SEQ_PWRGOOD_EN
  input  logic            PWR_GOOD,
  output logic            FAULT,
`endif
  output logic [NSEG-1:0] SEG_EN,
  output logic            BUSY,
  output logic            READY
);

  localparam int              LW      = lvl_width(NSEG);
  localparam int              CW      = cnt_width(SETTLE_CYC);
  localparam logic [LW-1:0]   LVL_TOP = LW'(NSEG);

  state_t        state, state_nxt;
  logic [LW-1:0] lvl, lvl_nxt, lvl_dn;
  logic          step_down;
  logic          tmr_load, tmr_clr, tmr_zero;
  logic          pg_fail, start_ok;

  function automatic logic [NSEG-1:0] therm(input logic [LW-1:0] l);
    logic [NSEG-1:0] t;
    for (int i = 0; i < NSEG; i++) t[i] = (i < int'(l));
    return t;
  endfunction

`ifdef GF180MCU_FD_IO_SEG_SEQ_PWRGOOD_EN
  // Power loss while segments are live drops everything at once, no staging.
  assign pg_fail  = !PWR_GOOD && (state == UP || state == ON);
  assign start_ok = START && !FAULT;

  always_ff @(posedge CLK) begin
    if (RST) begin
      FAULT <= 1'b0;
    end else if (pg_fail) begin
      FAULT <= 1'b1;
    end
  end
`else
  assign pg_fail  = 1'b0;
  assign start_ok = START;
`endif

  always_comb begin
    state_nxt = state;
    lvl_nxt   = lvl;
    tmr_load  = 1'b0;
    tmr_clr   = 1'b0;
    step_down = 1'b0;
    lvl_dn    = lvl - LW'(1);
    if (pg_fail) begin
      state_nxt = OFF;
      lvl_nxt   = '0;
      tmr_clr   = 1'b1;
    end else begin
      case (state)
        OFF: begin
          if (start_ok && !STOP) begin
            state_nxt = UP;
            lvl_nxt   = LW'(1);
            tmr_load  = 1'b1;
          end
        end
        UP: begin
          if (STOP) begin
            step_down = 1'b1;
          end else if (tmr_zero) begin
            if (lvl == LVL_TOP) begin
              state_nxt = ON;
            end else begin
              lvl_nxt  = lvl + LW'(1);
              tmr_load = 1'b1;
            end
          end
        end
        ON: begin
          if (STOP) step_down = 1'b1;
        end
        DOWN: begin
          // STOP outranks START, and STOP alone is already what DOWN is doing.
          if (start_ok && !STOP) begin
            state_nxt = UP;
            lvl_nxt   = lvl + LW'(1);
            tmr_load  = 1'b1;
          end else if (tmr_zero) begin
            step_down = 1'b1;
          end
        end
        default: state_nxt = OFF;
      endcase
      // Clearing the last segment lands directly in OFF on the same edge.
      if (step_down) begin
        lvl_nxt = lvl_dn;
        if (lvl_dn == '0) begin
          state_nxt = OFF;
          tmr_clr   = 1'b1;
        end else begin
          state_nxt = DOWN;
          tmr_load  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= OFF;
      lvl    <= '0;
      SEG_EN <= '0;
      BUSY   <= 1'b0;
      READY  <= 1'b0;
    end else begin
      state  <= state_nxt;
      lvl    <= lvl_nxt;
      SEG_EN <= therm(lvl_nxt);
      BUSY   <= (state_nxt == UP) || (state_nxt == DOWN);
      READY  <= (state_nxt == ON);
    end
  end

  gf180mcu_fd_io__seg_seq_tmr #(
    .SETTLE_CYC (SETTLE_CYC),
    .CW         (CW)
  ) u_tmr (
    .clk  (CLK),
    .rst  (RST),
    .clr  (tmr_clr),
    .load (tmr_load),
    .en   ((state == UP) || (state == DOWN)),
    .zero (tmr_zero)
  );

endmodule

// File: tb/tb_gf180mcu_fd_io__seg_seq.sv
// Bench for the segment sequencer: directed scenarios plus random traffic vs a schedule model.
module tb_gf180mcu_fd_io__seg_seq;

  localparam int N = 4;
  localparam int S = 3;

  localparam int M_OFF  = 0;
  localparam int M_UP   = 1;
  localparam int M_ON   = 2;
  localparam int M_DOWN = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [N-1:0] seg_en;
  logic         busy, ready;

  logic         start1 = 1'b0;
  logic         stop1 = 1'b0;
  logic [0:0]   seg1;
  logic         busy1, ready1;

`ifdef GF180MCU_FD_IO_SEG_SEQ_PWRGOOD_EN
  logic         pwr_good = 1'b1;
  logic         fault;
  logic         fault1;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: mode, level, and the absolute edge index of the next step.
  int cyc = 0;
  int m_mode = M_OFF;
  int m_lvl = 0;
  int m_t = 0;
  bit m_fault = 1'b0;

  always #5 clk = ~clk;

  gf180mcu_fd_io__seg_seq #(.NSEG(N), .SETTLE_CYC(S)) dut (
    .CLK      (clk),
    .RST      (rst),
    .START    (start),
    .STOP     (stop),
`ifdef GF180MCU_FD_IO_SEG_SEQ_PWRGOOD_EN
    .PWR_GOOD (pwr_good),
    .FAULT    (fault),
`endif
    .SEG_EN   (seg_en),
    .BUSY     (busy),
    .READY    (ready)
  );

  gf180mcu_fd_io__seg_seq #(.NSEG(1), .SETTLE_CYC(S)) dut1 (
    .CLK      (clk),
    .RST      (rst),
    .START    (start1),
    .STOP     (stop1),
`ifdef GF180MCU_FD_IO_SEG_SEQ_PWRGOOD_EN
    .PWR_GOOD (1'b1),
    .FAULT    (fault1),
`endif
    .SEG_EN   (seg1),
    .BUSY     (busy1),
    .READY    (ready1)
  );

  task automatic model_go_down();
    m_lvl = m_lvl - 1;
    if (m_lvl == 0) m_mode = M_OFF;
    else begin
      m_mode = M_DOWN;
      m_t = cyc + S;
    end
  endtask

  task automatic model_step();
    bit go;
    bit pg;
    pg = 1'b1;
`ifdef GF180MCU_FD_IO_SEG_SEQ_PWRGOOD_EN
    pg = pwr_good;
`endif
    go = start && !stop && !m_fault;
    if (rst) begin
      m_mode = M_OFF;
      m_lvl = 0;
      m_fault = 1'b0;
    end else if (!pg && (m_mode == M_UP || m_mode == M_ON)) begin
      m_mode = M_OFF;
      m_lvl = 0;
      m_fault = 1'b1;
    end else begin
      case (m_mode)
        M_OFF: if (go) begin m_mode = M_UP; m_lvl = 1; m_t = cyc + S; end
        M_UP: begin
          if (stop) model_go_down();
          else if (cyc == m_t) begin
            if (m_lvl == N) m_mode = M_ON;
            else begin m_lvl = m_lvl + 1; m_t = cyc + S; end
          end
        end
        M_ON: if (stop) model_go_down();
        default: begin
          if (go) begin m_mode = M_UP; m_lvl = m_lvl + 1; m_t = cyc + S; end
          else if (cyc == m_t) model_go_down();
        end
      endcase
    end
  endtask

  function automatic logic [N+1:0] exp_out();
    logic [N-1:0] s;
    s = N'((1 << m_lvl) - 1);
    return {s, (m_mode == M_UP || m_mode == M_DOWN) ? 1'b1 : 1'b0, (m_mode == M_ON) ? 1'b1 : 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; start1 = 1'b0; stop1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [N-1:0] seg_for(int k);
    logic [N-1:0] v;
    v = N'((1 << k) - 1);
    return v;
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if ({seg_en, busy, ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset got=%b exp=%b", {seg_en, busy, ready}, 6'b0);
    end
    checks++;
    if ({seg1, busy1, ready1} !== 3'b0) begin
      errors++;
      $display("FAIL reset_n1 got=%b exp=%b", {seg1, busy1, ready1}, 3'b0);
    end
  endtask

  task automatic test_power_up();
    logic [N+1:0] want;
    do_reset();
    start = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      tick();
      start = 1'b0;
      want = {seg_for((j < 4) ? 1 : (j < 7) ? 2 : (j < 10) ? 3 : 4),
              (j <= 12) ? 1'b1 : 1'b0, (j >= 13) ? 1'b1 : 1'b0};
      checks++;
      if ({seg_en, busy, ready} !== want) begin
        errors++;
        $display("FAIL power_up c%0d got=%b exp=%b", j, {seg_en, busy, ready}, want);
      end
      checks++;
      if ({seg_en, busy, ready} !== exp_out()) begin
        errors++;
        $display("FAIL power_up_model c%0d got=%b exp=%b", j, {seg_en, busy, ready}, exp_out());
      end
    end
  endtask

  task automatic test_power_down();
    logic [N+1:0] want;
    test_power_up();
    stop = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      tick();
      stop = 1'b0;
      want = {seg_for((j < 4) ? 3 : (j < 7) ? 2 : (j < 10) ? 1 : 0),
              (j <= 9) ? 1'b1 : 1'b0, 1'b0};
      checks++;
      if ({seg_en, busy, ready} !== want) begin
        errors++;
        $display("FAIL power_down +%0d got=%b exp=%b", j, {seg_en, busy, ready}, want);
      end
    end
  endtask

  task automatic test_reverse_in_up();
    logic [N+1:0] want;
    do_reset();
    start = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      tick();
      start = 1'b0;
      stop = (j == 5) ? 1'b1 : 1'b0;
      want = {seg_for((j < 4) ? 1 : (j < 6) ? 2 : (j < 9) ? 1 : 0),
              (j <= 8) ? 1'b1 : 1'b0, 1'b0};
      checks++;
      if ({seg_en, busy, ready} !== want) begin
        errors++;
        $display("FAIL reverse_up c%0d got=%b exp=%b", j, {seg_en, busy, ready}, want);
      end
    end
    stop = 1'b0;
  endtask

  task automatic test_both_requests();
    do_reset();
    start = 1'b1; stop = 1'b1;
    for (int j = 0; j < 3; j++) tick();
    checks++;
    if ({seg_en, busy, ready} !== 6'b0) begin
      errors++;
      $display("FAIL both_off got=%b exp=%b", {seg_en, busy, ready}, 6'b0);
    end
    stop = 1'b0;
    for (int j = 0; j < 14; j++) tick();
    start = 1'b0;
    checks++;
    if ({seg_en, busy, ready} !== {4'b1111, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL both_reach_on got=%b exp=%b", {seg_en, busy, ready}, {4'b1111, 1'b0, 1'b1});
    end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++;
    if ({seg_en, busy, ready} !== {4'b0111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL both_on got=%b exp=%b", {seg_en, busy, ready}, {4'b0111, 1'b1, 1'b0});
    end
  endtask

  task automatic test_reset_mid_up();
    do_reset();
    start = 1'b1;
    for (int j = 0; j < 7; j++) begin
      tick();
      start = 1'b0;
    end
    checks++;
    if (seg_en !== 4'b0111) begin
      errors++;
      $display("FAIL rst_mid_pre got=%b exp=%b", seg_en, 4'b0111);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({seg_en, busy, ready} !== 6'b0) begin
      errors++;
      $display("FAIL rst_mid got=%b exp=%b", {seg_en, busy, ready}, 6'b0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({seg_en, busy, ready} !== {4'b0001, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rst_restart got=%b exp=%b", {seg_en, busy, ready}, {4'b0001, 1'b1, 1'b0});
    end
  endtask

  task automatic test_nseg1();
    logic [2:0] want;
    do_reset();
    start1 = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      tick();
      start1 = 1'b0;
      want = {1'b1, (j <= 3) ? 1'b1 : 1'b0, (j >= 4) ? 1'b1 : 1'b0};
      checks++;
      if ({seg1, busy1, ready1} !== want) begin
        errors++;
        $display("FAIL nseg1_up c%0d got=%b exp=%b", j, {seg1, busy1, ready1}, want);
      end
    end
    stop1 = 1'b1;
    tick();
    stop1 = 1'b0;
    checks++;
    if ({seg1, busy1, ready1} !== 3'b000) begin
      errors++;
      $display("FAIL nseg1_down got=%b exp=%b", {seg1, busy1, ready1}, 3'b000);
    end
    tick();
    checks++;
    if ({seg1, busy1, ready1} !== 3'b000) begin
      errors++;
      $display("FAIL nseg1_off got=%b exp=%b", {seg1, busy1, ready1}, 3'b000);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 11) == 0);
      tick();
      checks++;
      if ({seg_en, busy, ready} !== exp_out()) begin
        errors++;
        $display("FAIL random i=%0d got=%b exp=%b", i, {seg_en, busy, ready}, exp_out());
      end
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

`ifdef GF180MCU_FD_IO_SEG_SEQ_PWRGOOD_EN
  task automatic test_pwr_good();
    do_reset();
    start = 1'b1;
    for (int j = 0; j < 14; j++) begin
      tick();
      start = 1'b0;
    end
    pwr_good = 1'b0;
    tick();
    pwr_good = 1'b1;
    checks++;
    if ({seg_en, busy, ready, fault} !== 7'b0000_0_0_1) begin
      errors++;
      $display("FAIL pg_drop got=%b exp=%b", {seg_en, busy, ready, fault}, 7'b0000_0_0_1);
    end
    start = 1'b1;
    for (int j = 0; j < 4; j++) tick();
    start = 1'b0;
    checks++;
    if ({seg_en, busy, fault} !== {seg_for(m_lvl), 1'b0, m_fault}) begin
      errors++;
      $display("FAIL pg_start_ignored got=%b exp=%b", {seg_en, busy, fault}, {seg_for(m_lvl), 1'b0, m_fault});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL pg_rst_clear got=%b exp=%b", fault, 1'b0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_reverse_in_up();
    test_both_requests();
    test_reset_mid_up();
    test_nseg1();
`ifdef GF180MCU_FD_IO_SEG_SEQ_PWRGOOD_EN
    test_pwr_good();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
